// File: rtl/mca_frame_tx.sv
// mca_frame_tx: streams one MCA spectrum frame from the histogram RAM read port
// to a byte-wide UART transmitter: HDR_LEN header bytes, then N_BINS bins of
// BIN_W bits each, optionally followed by a 16-bit byte-sum checksum.
//
// Optional feature: define MCA_TX_CHECKSUM_EN to append the checksum (2 bytes,
// MSB first) after the last bin.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         pulse, begin one frame (ignored while busy)
//   continuous    level, restart a new frame as soon as the previous one ends
//   tx_ready      UART idle / able to accept a byte
//   ram_data      RAM read data, valid one cycle after ram_addr
//   ram_addr      RAM read address
//   start_tx      one-cycle load strobe for the UART, tx_data valid with it
//   tx_data       byte to transmit, held until the next start_tx
//   busy          frame in progress
//   frame_done    one-cycle pulse after the last byte of a frame was accepted
module mca_frame_tx #(
  parameter int unsigned N_BINS    = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BIN_W     = 16,
  parameter int unsigned HDR_LEN   = 6,
  parameter logic [63:0] HDR       = 64'h0000_6c61_756e_6368,  // "launch"
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned ACK_TMO   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              tx_ready,
  input  logic [BIN_W-1:0]  ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              start_tx,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BPB   = BIN_W / 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = (ACK_TMO < 2) ? 1 : $clog2(ACK_TMO + 1);
  // Header left-aligned so header byte i always sits at bits [63-8i -: 8]
  localparam logic [63:0] HDR_ALIGN = HDR << (64 - 8 * HDR_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LOAD,
    ST_BIN,
`ifdef MCA_TX_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_e;

  // Per-byte handshake phase: wait for ready, then wait for accept/timeout
  typedef enum logic {PH_RDY, PH_ACK} phase_e;

  state_e            state_q, state_d;
  phase_e            ph_q, ph_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]  bin_idx_q, bin_idx_d;
  logic [BIN_W-1:0]  bin_sr_q, bin_sr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              start_tx_q, start_tx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
`ifdef MCA_TX_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  logic [7:0] hdr_byte_c;
  logic [7:0] cur_byte_c;
  logic       last_byte_c;
  logic       in_send_c;
  logic       ack_c;

  // Header byte selected by byte_idx
  always_comb begin
    hdr_byte_c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (byte_idx_q == IDX_W'(i)) hdr_byte_c = HDR_ALIGN[8*(7-i) +: 8];
    end
  end

  // Byte to send in the current state and whether it is the state's last one
  always_comb begin
    cur_byte_c  = 8'h00;
    last_byte_c = 1'b0;
    in_send_c   = 1'b0;
    case (state_q)
      ST_HDR: begin
        in_send_c   = 1'b1;
        cur_byte_c  = hdr_byte_c;
        last_byte_c = (byte_idx_q == IDX_W'(HDR_LEN - 1));
      end
      ST_BIN: begin
        in_send_c   = 1'b1;
        cur_byte_c  = MSB_FIRST ? bin_sr_q[BIN_W-1 -: 8] : bin_sr_q[7:0];
        last_byte_c = (byte_idx_q == IDX_W'(BPB - 1));
      end
`ifdef MCA_TX_CHECKSUM_EN
      ST_CSUM: begin
        in_send_c   = 1'b1;
        cur_byte_c  = (byte_idx_q == '0) ? csum_q[15:8] : csum_q[7:0];
        last_byte_c = (byte_idx_q == IDX_W'(1));
      end
`endif
      default: ;
    endcase
  end

  // Byte counts as sent once the UART drops ready or the ack timeout expires
  assign ack_c = in_send_c && (ph_q == PH_ACK) &&
                 (!tx_ready || (tmo_q >= TMO_W'(ACK_TMO)));

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    tmo_d        = tmo_q;
    byte_idx_d   = byte_idx_q;
    bin_idx_d    = bin_idx_q;
    bin_sr_d     = bin_sr_q;
    ram_addr_d   = ram_addr_q;
    start_tx_d   = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
`ifdef MCA_TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    // Shared byte handshake for HDR / BIN / CSUM
    if (in_send_c) begin
      if (ph_q == PH_RDY) begin
        if (tx_ready) begin
          start_tx_d = 1'b1;
          tx_data_d  = cur_byte_c;
          ph_d       = PH_ACK;
          tmo_d      = '0;
          if (state_q == ST_BIN) begin
            bin_sr_d = MSB_FIRST ? (bin_sr_q << 8) : (bin_sr_q >> 8);
`ifdef MCA_TX_CHECKSUM_EN
            csum_d   = csum_q + 16'(cur_byte_c);
`endif
          end
        end
      end else if (ack_c) begin
        ph_d       = PH_RDY;
        byte_idx_d = last_byte_c ? '0 : byte_idx_q + IDX_W'(1);
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start || continuous) begin
          busy_d     = 1'b1;
          byte_idx_d = '0;
          bin_idx_d  = '0;
          ram_addr_d = '0;
          ph_d       = PH_RDY;
`ifdef MCA_TX_CHECKSUM_EN
          csum_d     = '0;
`endif
          state_d    = (HDR_LEN == 0) ? ST_FETCH : ST_HDR;
        end
      end
      ST_HDR: begin
        if (ack_c && last_byte_c) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Address is already stable here; RAM returns data during LOAD
        ram_addr_d = ADDR_W'(bin_idx_q);
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        bin_sr_d   = ram_data;
        byte_idx_d = '0;
        ph_d       = PH_RDY;
        state_d    = ST_BIN;
      end
      ST_BIN: begin
        if (ack_c && last_byte_c) begin
          if (bin_idx_q == CNT_W'(N_BINS - 1)) begin
`ifdef MCA_TX_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            bin_idx_d  = bin_idx_q + CNT_W'(1);
            ram_addr_d = ADDR_W'(bin_idx_q + CNT_W'(1));
            state_d    = ST_FETCH;
          end
        end
      end
`ifdef MCA_TX_CHECKSUM_EN
      ST_CSUM: begin
        if (ack_c && last_byte_c) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        ram_addr_d   = '0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ph_q         <= PH_RDY;
      tmo_q        <= '0;
      byte_idx_q   <= '0;
      bin_idx_q    <= '0;
      bin_sr_q     <= '0;
      ram_addr_q   <= '0;
      start_tx_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MCA_TX_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      tmo_q        <= tmo_d;
      byte_idx_q   <= byte_idx_d;
      bin_idx_q    <= bin_idx_d;
      bin_sr_q     <= bin_sr_d;
      ram_addr_q   <= ram_addr_d;
      start_tx_q   <= start_tx_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef MCA_TX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign ram_addr   = ram_addr_q;
  assign start_tx   = start_tx_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
